// File: rtl/sram_ctrl.sv
// Initiator-side controller for the on-chip sram: one request at a time, strobe, wait, respond.
// Optional address range check enabled by defining SRAM_CTRL_ADDR_CHECK_EN.
module sram_ctrl #(
  parameter int ADDRESS = 20,
  parameter int DATA    = 8,
  parameter int DEPTH   = 20,
  parameter int WAIT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDRESS-1:0] req_addr,
  input  logic [DATA-1:0]    req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA-1:0]    rsp_rdata,
  output logic               rsp_err,
  output logic               sram_cs,
  output logic               sram_read,
  output logic               sram_write,
  output logic [ADDRESS-1:0] sram_addr,
  output logic [DATA-1:0]    sram_wdata,
  input  logic [DATA-1:0]    sram_rdata
);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [ADDRESS-1:0] addr_q, addr_d;
  logic [DATA-1:0]    wdata_q, wdata_d;
  logic [DATA-1:0]    rdata_q, rdata_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               cs_q, cs_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               rv_q, rv_d;
  logic               rr_q, rr_d;
  logic               err_q, err_d;
  logic               addr_bad;

  assign addr_bad = ADDR_CHECK && (req_addr >= ADDRESS'(DEPTH));

  // All pin-facing outputs are registered, so strobe/ready decisions are made one edge early.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    err_d   = err_q;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        rr_d = 1'b1;
        if (req_valid && rr_q) begin
          rr_d = 1'b0;
          if (addr_bad) begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_STROBE;
            op_d    = req_write;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            err_d   = 1'b0;
            cs_d    = 1'b1;
            wr_d    = req_write;
            rd_d    = !req_write;
          end
        end
      end
      S_STROBE: begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT);
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
          rv_d    = 1'b1;
          rdata_d = op_q ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
          rr_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rv_q    <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rv_q    <= rv_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = rr_q;
  assign rsp_valid  = rv_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign sram_cs    = cs_q;
  assign sram_read  = rd_q;
  assign sram_write = wr_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: WAIT=1 instance with randomized traffic and a WAIT=3 instance.
// Expectations come from a word-array reference of the memory and the handshake latency rules.
module tb_sram_ctrl;
  localparam int AW = 20;
  localparam int DW = 8;
  localparam int DEPTH = 20;
  localparam int W1 = 1;
  localparam int W3 = 3;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
  localparam bit ACHK = 1'b1;
`else
  localparam bit ACHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [AW-1:0] req_addr, sram_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
  logic          sram_cs, sram_read, sram_write;

  logic          req_valid3, req_ready3, req_write3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [AW-1:0] req_addr3, sram_addr3;
  logic [DW-1:0] req_wdata3, rsp_rdata3, sram_wdata3, sram_rdata3;
  logic          sram_cs3, sram_read3, sram_write3;

  sram_ctrl #(.ADDRESS(AW), .DATA(DW), .DEPTH(DEPTH), .WAIT(W1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_cs(sram_cs), .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  sram_ctrl #(.ADDRESS(AW), .DATA(DW), .DEPTH(DEPTH), .WAIT(W3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .sram_cs(sram_cs3), .sram_read(sram_read3), .sram_write(sram_write3),
    .sram_addr(sram_addr3), .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3)
  );

  // Behavioural SRAMs with one-cycle registered read.
  logic [DW-1:0] mem0 [32] = '{default: '0};
  logic [DW-1:0] mem3 [32] = '{default: '0};
  always @(posedge clk) begin
    if (sram_cs && sram_write) mem0[sram_addr[4:0]] <= sram_wdata;
    if (sram_cs && sram_read)  sram_rdata <= mem0[sram_addr[4:0]];
  end
  always @(posedge clk) begin
    if (sram_cs3 && sram_write3) mem3[sram_addr3[4:0]] <= sram_wdata3;
    if (sram_cs3 && sram_read3)  sram_rdata3 <= mem3[sram_addr3[4:0]];
  end

  int cs3_cnt = 0;
  always @(posedge clk) if (sram_cs3) cs3_cnt <= cs3_cnt + 1;

  logic [DW-1:0] ref_mem [32];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on u0; rsp_valid is expected after the (WAIT+1)-th edge following acceptance.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    int n;
    int k;
    bit bad;
    logic [DW-1:0] er;
    bad = ACHK && (a >= AW'(DEPTH));
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(n < 50), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ready_drop", 32'(req_ready), 0);
    if (bad) begin
      chk("no_strobe", {sram_cs, sram_read, sram_write}, 0);
    end else begin
      chk("strobe_cs", 32'(sram_cs), 1);
      chk("strobe_wr", 32'(sram_write), 32'(wr));
      chk("strobe_rd", 32'(sram_read), 32'(!wr));
      chk("strobe_addr", 32'(sram_addr), 32'(a));
      chk("strobe_wdata", 32'(sram_wdata), 32'(d));
    end
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
      if (rsp_valid !== 1'b1) chk("cs_idle", {sram_cs, sram_read, sram_write}, 0);
    end
    chk("latency", k, bad ? 0 : W1 + 1);
    if (bad) er = '0;
    else if (wr) begin ref_mem[a[4:0]] = d; er = '0; end
    else er = ref_mem[a[4:0]];
    chk("rdata", 32'(rsp_rdata), 32'(er));
    chk("err", 32'(rsp_err), 32'(bad));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", 32'(rsp_rdata), 32'(er));
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_cs", 32'(sram_cs), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", 32'(rsp_valid), 0);
    chk("idle_ready", 32'(req_ready), 1);
  endtask

  task automatic txn3(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] er);
    int n;
    int k;
    int c0;
    req_write3 = wr; req_addr3 = a; req_wdata3 = d; req_valid3 = 1'b1; rsp_ready3 = 1'b1;
    n = 0;
    while (req_ready3 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("w3_ready_wait", 32'(n < 50), 1);
    c0 = cs3_cnt;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    k = 0;
    while (rsp_valid3 !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("w3_latency", k, W3 + 1);
    chk("w3_cs_pulses", cs3_cnt - c0, 1);
    chk("w3_rdata", 32'(rsp_rdata3), 32'(er));
    chk("w3_err", 32'(rsp_err3), 0);
    @(posedge clk); #1;
    chk("w3_done", 32'(rsp_valid3), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(5); req_wdata = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ctrl", {req_ready, rsp_valid, rsp_err, sram_cs, sram_read, sram_write}, 0);
      chk("rst_data", {rsp_rdata, sram_wdata}, 0);
      chk("rst_addr", 32'(sram_addr), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rdy_after_release", 32'(req_ready), 1);
    chk("no_cs_after_release", 32'(sram_cs), 0);

    txn(1'b1, AW'(5), 8'hA5, 0);
    txn(1'b0, AW'(5), 8'h00, 0);
    txn(1'b0, AW'(5), 8'h00, 10);

    // Reset while a read sits in its wait phase.
    req_write = 1'b0; req_addr = AW'(5); req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midop_strobe", 32'(sram_cs), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midop_rst", {rsp_valid, req_ready, sram_cs}, 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midop_no_rsp", 32'(rsp_valid), 0);
    end
    txn(1'b0, AW'(5), 8'h00, 0);

    txn(1'b0, AW'(DEPTH), 8'h00, 1);
    txn(1'b1, AW'(DEPTH + 1), 8'h77, 0);
    txn(1'b0, AW'(DEPTH + 1), 8'h00, 0);
    txn(1'b0, AW'(DEPTH - 1), 8'h00, 0);

    repeat (40) begin
      txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
          int'($urandom_range(0, 3)));
    end

    txn3(1'b1, AW'(2), 8'h3C, 8'h00);
    txn3(1'b0, AW'(2), 8'h00, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
